// File: rtl/cnt_desc_timer.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// Optional prescaler is built when CNT_DESC_PRESCALE_EN is defined.
module cnt_desc_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic             ena,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_param_check
    $error("cnt_desc_timer: WIDTH or PRESCALE out of range");
  end

  state_e           state;
  logic [WIDTH-1:0] reload_reg;
  logic             load_acc;
  logic             step;

  assign load_ready = (state == StIdle) && !srst;
  assign load_acc   = load_valid && load_ready;
  assign busy       = (state == StRun);

`ifdef CNT_DESC_PRESCALE_EN
  localparam int unsigned PsW = $clog2(PRESCALE);
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] prescaler;

  // A decrement step only on the last enabled cycle of each prescale period.
  assign step = ena && (prescaler == PsLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (srst || load_acc) begin
      prescaler <= '0;
    end else if (state == StRun && ena) begin
      prescaler <= (prescaler == PsLast) ? '0 : prescaler + PsW'(1);
    end
  end
`else
  assign step = ena;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      dout       <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else if (srst) begin
      state      <= StIdle;
      dout       <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else if (load_acc) begin
      dout       <= load_val;
      reload_reg <= load_val;
      // A zero load expires immediately without ever entering RUN.
      if (load_val != '0) begin
        state <= StRun;
        tc    <= 1'b0;
      end else begin
        state <= StIdle;
        tc    <= 1'b1;
      end
    end else if (state == StRun) begin
      tc <= 1'b0;
      if (step) begin
        if (dout > One) begin
          dout <= dout - One;
        end else begin
          tc <= 1'b1;
          if (auto_reload) begin
            dout <= reload_reg;
          end else begin
            dout  <= '0;
            state <= StIdle;
          end
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_desc_timer.sv
// Directed bench for cnt_desc_timer: expected outputs are queued as stimulus is
// driven and compared after each clock edge.
module tb_cnt_desc_timer;

  localparam int unsigned W = 16;
`ifdef CNT_DESC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         srst = 1'b0;
  logic         ena = 1'b0;
  logic         load_valid = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         load_ready;
  logic         busy;
  logic         tc;
  logic [W-1:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string tag;
    int    dout;
    bit    tc;
    bit    busy;
    bit    rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cnt_desc_timer #(
    .WIDTH   (W),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srst       (srst),
    .ena        (ena),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .dout       (dout),
    .busy       (busy),
    .tc         (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input bit lv, input int lval, input bit en, input bit ar, input bit sr);
    logic [31:0] v;
    v           = lval;
    load_valid  = lv;
    load_val    = v[W-1:0];
    ena         = en;
    auto_reload = ar;
    srst        = sr;
  endtask

  task automatic push_exp(input string tag, input int d, input bit t, input bit b, input bit r);
    exp_t e;
    e.tag  = tag;
    e.dout = d;
    e.tc   = t;
    e.busy = b;
    e.rdy  = r;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".dout"}, 32'(dout), e.dout);
    chk({e.tag, ".tc"}, 32'(tc), 32'(e.tc));
    chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({e.tag, ".ready"}, 32'(load_ready), 32'(e.rdy));
  endtask

  initial begin
    int e_cnt;
    int d;
    int lat;
    bit en;

    // Power-on reset.
    #2;
    chk("por.dout", 32'(dout), 0);
    chk("por.tc", 32'(tc), 0);
    chk("por.busy", 32'(busy), 0);
    chk("por.ready", 32'(load_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One-shot load 5.
    drive(1, 5, 1, 0, 0);
    push_exp("oneshot.load", 5, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    for (int k = 1; k <= 5 * PS; k++) begin
      push_exp("oneshot.run", 5 - k / PS, k == 5 * PS, k < 5 * PS, k >= 5 * PS);
      tick();
    end
    push_exp("oneshot.idle", 0, 0, 0, 1);
    tick();

    // Periodic load 3, then one-shot finish.
    drive(1, 3, 1, 1, 0);
    push_exp("periodic.load", 3, 0, 1, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    for (int k = 1; k <= 12 * PS; k++) begin
      d = k / PS;
      push_exp("periodic.run", 3 - d % 3, (k % PS == 0) && (d % 3 == 0), 1, 0);
      tick();
    end
    drive(0, 0, 1, 0, 0);
    for (int k = 1; k <= 3 * PS; k++) begin
      push_exp("periodic.stop", 3 - k / PS, k == 3 * PS, k < 3 * PS, k >= 3 * PS);
      tick();
    end

    // Enable gating: ena toggles 1,0,1,0...
    drive(1, 4, 0, 0, 0);
    push_exp("gate.load", 4, 0, 1, 0);
    tick();
    e_cnt = 0;
    for (int c = 1; c <= 8 * PS; c++) begin
      en = (c % 2 == 1);
      drive(0, 0, en, 0, 0);
      if (en) e_cnt++;
      push_exp("gate.run", 4 - e_cnt / PS, en && (e_cnt == 4 * PS), e_cnt < 4 * PS,
               e_cnt >= 4 * PS);
      tick();
    end

    // Load 0: immediate expiry, never busy.
    drive(1, 0, 1, 0, 0);
    push_exp("zero.load", 0, 1, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    push_exp("zero.after", 0, 0, 0, 1);
    tick();

    // Periodic N=1: tc on every decrement step, then srst stops it.
    drive(1, 1, 1, 1, 0);
    push_exp("n1.load", 1, 0, 1, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    for (int k = 1; k <= 3 * PS; k++) begin
      push_exp("n1.run", 1, k % PS == 0, 1, 0);
      tick();
    end
    drive(0, 0, 1, 1, 1);
    push_exp("n1.srst", 0, 0, 0, 0);
    tick();

    // load_valid while running is ignored.
    drive(1, 7, 0, 0, 0);
    push_exp("runload.first", 7, 0, 1, 0);
    tick();
    drive(1, 2, 0, 0, 0);
    #1;
    chk("runload.ready_comb", 32'(load_ready), 0);
    push_exp("runload.held", 7, 0, 1, 0);
    tick();

    // srst and load_valid on the same edge: srst wins.
    drive(1, 9, 1, 0, 1);
    #1;
    chk("srstload.ready_comb", 32'(load_ready), 0);
    push_exp("srstload.edge", 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    push_exp("srstload.after", 0, 0, 0, 1);
    tick();

    // Asynchronous reset mid-run at dout=7.
    drive(1, 7, 0, 0, 0);
    push_exp("arst.load", 7, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.dout", 32'(dout), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.tc", 32'(tc), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst.ready", 32'(load_ready), 1);
    push_exp("arst.after", 0, 0, 0, 1);
    tick();

    // Expiry latency for load 2 with ena held high, bounded wait.
    drive(1, 2, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 1, 0, 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (tc) begin
        lat = i;
        break;
      end
    end
    chk("latency.load2", 32'(lat), 32'(2 * PS));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
